demux_n_stream: RTL and testbench

//   Registered 1:2^N stream demultiplexer. Routes each valid/ready beat from one

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_stage.sv | 54 +++++
 rtl/demux_n_stream.sv | 125 ++++++++++++
 tb/tb_demux_n_stream.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and index helpers for the 1:2^N stream demultiplexer tree.
package demux_pkg;

    localparam int unsigned MAX_N = 8;

    function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

    // Flat index of the first stage of tree level l.
    function automatic int unsigned stage_base(input int unsigned l);
        return (32'd1 << l) - 32'd1;
    endfunction

endpackage

// File: rtl/demux_stage.sv
// One registered 1:2 stream stage; routes on the MSB of its held select and
// forwards the remaining select bits to the chosen child.
module demux_stage #(
    parameter int unsigned W   = 8,
    parameter int unsigned SW  = 1,
    localparam int unsigned OSW = (SW > 1) ? SW - 1 : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [W-1:0]   in_data,
    input  logic [SW-1:0]  in_sel,
    output logic [1:0]     out_vld,
    input  logic [1:0]     out_rdy,
    output logic [W-1:0]   out_data,
    output logic [OSW-1:0] out_sel
);

    logic          full_q;
    logic [W-1:0]  data_q;
    logic [SW-1:0] sel_q;
    logic          route_c;
    logic          child_rdy_c;

    assign route_c     = sel_q[SW-1];
    assign child_rdy_c = out_rdy[route_c];
    assign in_rdy      = !full_q || child_rdy_c;

    // A new beat may replace a draining one on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            sel_q  <= '0;
        end else if (in_vld && in_rdy) begin
            full_q <= 1'b1;
            data_q <= in_data;
            sel_q  <= in_sel;
        end else if (child_rdy_c) begin
            full_q <= 1'b0;
        end
    end

    assign out_vld  = {full_q && route_c, full_q && !route_c};
    assign out_data = data_q;

    if (SW > 1) begin : g_fwd_sel
        assign out_sel = sel_q[SW-2:0];
    end else begin : g_no_sel
        assign out_sel = '0;
    end

endmodule

// File: rtl/demux_n_stream.sv
// Registered 1:2^N valid/ready demultiplexer built as an N-level tree of 1:2
// stages, MSB of in_sel routed first; ready is combinational back to the input.
module demux_n_stream
    import demux_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned W = 8,
    localparam int unsigned NCH  = 32'd1 << N,
    localparam int unsigned SELW = (N == 0) ? 1 : N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic [SELW-1:0]   in_sel,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*W-1:0]  out_data,
    output logic              busy
);

    localparam int unsigned NL = (N == 0) ? 1 : N;
    localparam int unsigned NS = (N == 0) ? 1 : NCH - 1;

    // Residual select width held by stages of level l.
    function automatic int unsigned sw_of(input int unsigned l);
        return (N == 0) ? 1 : N - l;
    endfunction

    // Offset of level l inside the packed residual-select bus.
    function automatic int unsigned sel_off(input int unsigned l);
        int unsigned o;
        o = 0;
        for (int unsigned m = 0; m < l; m++) begin
            o += (32'd1 << m) * sw_of(m);
        end
        return o;
    endfunction

    localparam int unsigned SELT = sel_off(NL);

    logic [NS-1:0]         st_vld;
    logic [NS-1:0]         st_rdy;
    logic [NS-1:0]         st_full;
    logic [NS-1:0][W-1:0]  st_data;
    logic [SELT-1:0]       st_sel;

    assign st_vld[0]  = in_valid;
    assign st_data[0] = in_data;
    assign in_ready   = st_rdy[0] && !rst;
    assign busy       = |st_full;

    if (N == 0) begin : g_sel_none
        assign st_sel[0] = 1'b0;
    end else begin : g_sel_root
        assign st_sel[N-1:0] = in_sel;
    end

    for (genvar l = 0; l < NL; l++) begin : g_lvl
        localparam int unsigned SW = sw_of(l);
        for (genvar j = 0; j < (1 << l); j++) begin : g_stg
            localparam int unsigned S   = stage_base(l) + j;
            localparam int unsigned OFF = sel_off(l) + j * SW;

            logic [1:0]   vld_c;
            logic [1:0]   rdy_c;
            logic [W-1:0] data_c;

            assign st_full[S] = |vld_c;

            if (l + 1 < NL) begin : g_node
                localparam int unsigned C    = stage_base(l + 1) + 2 * j;
                localparam int unsigned COFF = sel_off(l + 1) + 2 * j * (SW - 1);
                logic [SW-2:0] sel_c;

                demux_stage #(.W(W), .SW(SW)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .in_vld   (st_vld[S]),
                    .in_rdy   (st_rdy[S]),
                    .in_data  (st_data[S]),
                    .in_sel   (st_sel[OFF +: SW]),
                    .out_vld  (vld_c),
                    .out_rdy  (rdy_c),
                    .out_data (data_c),
                    .out_sel  (sel_c)
                );

                assign st_vld[C]                  = vld_c[0];
                assign st_vld[C+1]                = vld_c[1];
                assign st_data[C]                 = data_c;
                assign st_data[C+1]               = data_c;
                assign st_sel[COFF +: SW-1]       = sel_c;
                assign st_sel[COFF+SW-1 +: SW-1]  = sel_c;
                assign rdy_c                      = {st_rdy[C+1], st_rdy[C]};
            end else begin : g_leaf
                demux_stage #(.W(W), .SW(SW)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .in_vld   (st_vld[S]),
                    .in_rdy   (st_rdy[S]),
                    .in_data  (st_data[S]),
                    .in_sel   (st_sel[OFF +: SW]),
                    .out_vld  (vld_c),
                    .out_rdy  (rdy_c),
                    .out_data (data_c),
                    .out_sel  ()
                );

                // N==0 degenerates to a single slice whose select is tied low.
                if (N == 0) begin : g_single
                    assign out_valid = vld_c[0];
                    assign out_data  = data_c;
                    assign rdy_c     = {1'b0, out_ready[0]};
                end else begin : g_pair
                    assign out_valid[2*j +: 2]                 = vld_c;
                    assign out_data[chan_lsb(2*j, W) +: 2*W]   = {data_c, data_c};
                    assign rdy_c                               = out_ready[2*j +: 2];
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_n_stream.sv
// Directed and randomized bench for demux_n_stream at N=3, N=1 and N=0.
module tb_demux_n_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, busy;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_valid, out_ready;
    logic [63:0] out_data;

    logic        v1, rdy1, busy1;
    logic [7:0]  d1;
    logic [0:0]  s1;
    logic [1:0]  ov1, r1;
    logic [15:0] od1;

    logic        v0, rdy0, busy0;
    logic [7:0]  d0;
    logic [0:0]  s0, ov0, r0;
    logic [7:0]  od0;

    int checks = 0;
    int errors = 0;

    demux_n_stream #(.N(3), .W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    demux_n_stream #(.N(1), .W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .in_data(d1), .in_sel(s1), .out_valid(ov1),
        .out_ready(r1), .out_data(od1), .busy(busy1)
    );

    demux_n_stream #(.N(0), .W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
        .in_data(d0), .in_sel(s0), .out_valid(ov0),
        .out_ready(r0), .out_data(od0), .busy(busy0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected beats per channel, pushed on accept, popped on emit.
    logic [7:0] exp_q [8][$];
    logic [7:0] stall;
    logic [7:0] stall_d [8];

    function automatic int qtotal();
        int t;
        t = 0;
        for (int k = 0; k < 8; k++) t += exp_q[k].size();
        return t;
    endfunction

    always @(negedge clk) begin
        logic [7:0] d;
        logic [7:0] e;
        if (rst) begin
            for (int k = 0; k < 8; k++) exp_q[k].delete();
            stall = '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                d = out_data[k*8 +: 8];
                if (stall[k])
                    chk($sformatf("hold_ch%0d", k), {55'd0, out_valid[k], d}, {55'd0, 1'b1, stall_d[k]});
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_ch%0d", k), 64'(d), 64'hFFFF);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("order_ch%0d", k), 64'(d), 64'(e));
                    end
                end
                stall[k]   = out_valid[k] && !out_ready[k];
                stall_d[k] = d;
            end
            if (in_valid && in_ready) exp_q[in_sel].push_back(in_data);
        end
    end

    task automatic send3(input logic [2:0] s, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || qtotal() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_left", 64'(qtotal()), 64'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       vld;
        logic [2:0] sel;
        logic [7:0] data;
        logic       rdy;
        logic [7:0] ov;
        logic [7:0] od;
    } vec_t;

    vec_t tv [11];

    initial begin
        // Back-to-back sweep of all channels: each beat appears 3 cycles later.
        tv[0]  = '{1'b1, 3'd0, 8'hA0, 1'b1, 8'h00, 8'h00};
        tv[1]  = '{1'b1, 3'd1, 8'hA1, 1'b1, 8'h00, 8'h00};
        tv[2]  = '{1'b1, 3'd2, 8'hA2, 1'b1, 8'h00, 8'h00};
        tv[3]  = '{1'b1, 3'd3, 8'hA3, 1'b1, 8'h01, 8'hA0};
        tv[4]  = '{1'b1, 3'd4, 8'hA4, 1'b1, 8'h02, 8'hA1};
        tv[5]  = '{1'b1, 3'd5, 8'hA5, 1'b1, 8'h04, 8'hA2};
        tv[6]  = '{1'b1, 3'd6, 8'hA6, 1'b1, 8'h08, 8'hA3};
        tv[7]  = '{1'b1, 3'd7, 8'hA7, 1'b1, 8'h10, 8'hA4};
        tv[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h20, 8'hA5};
        tv[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h40, 8'hA6};
        tv[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h80, 8'hA7};

        rst = 1'b1;
        in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = 8'hFF;
        v1 = 1'b0; s1 = '0; d1 = '0; r1 = 2'b11;
        v0 = 1'b0; s0 = '0; d0 = '0; r0 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ov1", 64'(ov1), 64'd0);
        chk("rst_ov0", 64'(ov0), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Table sweep
        for (int i = 0; i < 11; i++) begin
            in_valid = tv[i].vld;
            in_sel   = tv[i].sel;
            in_data  = tv[i].data;
            @(negedge clk);
            chk($sformatf("t1_rdy_%0d", i), 64'(in_ready), 64'(tv[i].rdy));
            chk($sformatf("t1_ov_%0d", i), 64'(out_valid), 64'(tv[i].ov));
            for (int k = 0; k < 8; k++)
                if (tv[i].ov[k])
                    chk($sformatf("t1_od_%0d", i), 64'(out_data[k*8 +: 8]), 64'(tv[i].od));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Stalled channel 5 blocks only its own path
        out_ready = 8'hDF;
        send3(3'd5, 8'h55);
        send3(3'd2, 8'h22);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_ch2_valid", 64'(out_valid[2]), 64'd1);
        chk("t2_ch2_data", 64'(out_data[23:16]), 64'h22);
        chk("t2_ch5_held", 64'({out_valid[5], out_data[47:40]}), 64'h155);
        @(posedge clk); #1;
        send3(3'd4, 8'h41);
        send3(3'd4, 8'h42);
        in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h43;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_backpressure", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        chk("t2_ch5_still", 64'({out_valid[5], out_data[47:40]}), 64'h155);
        out_ready = 8'hFF;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("t2_release_accept", 64'(in_ready), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset with beats in flight
        out_ready = 8'h00;
        send3(3'd1, 8'h11);
        send3(3'd2, 8'h12);
        send3(3'd3, 8'h13);
        @(negedge clk);
        chk("t3_busy_before", 64'(busy), 64'd1);
        chk("t3_ov_before", 64'(out_valid), 64'h02);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t3_rdy_in_rst", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 8'hFF;
        @(negedge clk);
        chk("t3_ov_after", 64'(out_valid), 64'd0);
        chk("t3_busy_after", 64'(busy), 64'd0);
        chk("t3_rdy_after", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t3_no_emit", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // N=1: one register stage
        v1 = 1'b1; s1 = 1'b1; d1 = 8'h3C;
        @(negedge clk);
        chk("n1_rdy", 64'(rdy1), 64'd1);
        @(posedge clk); #1;
        s1 = 1'b0; d1 = 8'h5A;
        @(negedge clk);
        chk("n1_ov_a", 64'(ov1), 64'h2);
        chk("n1_od_a", 64'(od1[15:8]), 64'h3C);
        @(posedge clk); #1;
        v1 = 1'b0;
        @(negedge clk);
        chk("n1_ov_b", 64'(ov1), 64'h1);
        chk("n1_od_b", 64'(od1[7:0]), 64'h5A);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n1_idle", 64'({busy1, ov1}), 64'd0);
        @(posedge clk); #1;

        // N=0: single slice, replace-on-drain without a bubble
        r0 = 1'b0; v0 = 1'b1; d0 = 8'h77;
        @(negedge clk);
        chk("n0_rdy_empty", 64'(rdy0), 64'd1);
        @(posedge clk); #1;
        d0 = 8'h88;
        @(negedge clk);
        chk("n0_out_a", 64'({ov0, od0}), 64'h177);
        chk("n0_rdy_full", 64'(rdy0), 64'd0);
        @(posedge clk); #1;
        r0 = 1'b1;
        @(negedge clk);
        chk("n0_out_hold", 64'({ov0, od0}), 64'h177);
        chk("n0_rdy_drain", 64'(rdy0), 64'd1);
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        chk("n0_out_b", 64'({ov0, od0}), 64'h188);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n0_idle", 64'({busy0, ov0}), 64'd0);
        @(posedge clk); #1;

        // Random traffic against the scoreboard
        begin
            logic acc;
            acc = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if (!in_valid || acc) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_sel   = 3'($urandom);
                    in_data  = 8'($urandom);
                end
                out_ready = 8'($urandom);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        out_ready = 8'hFF;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
